instr_fetch: RTL and testbench

INSTR_FETCH -- requirements
Module: instr_fetch

---
 rtl/instr_fetch.sv | 146 ++++++++++++++
 tb/tb_instr_fetch.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
// ----------------------------------------------------------------------------
// instr_fetch -- instruction prefetch unit with a small FIFO buffer.
//
// Issues sequential word reads to a synchronous instruction memory (read data
// arrives one cycle after the strobe). Each response is buffered with its pc
// and handed to decode over a valid/ready interface. Supports redirects
// (flush + restart) and a halt request that stops issue and drains.
//
// Ports:
//   clk, resetn          clock, asynchronous active-low reset
//   mem_r_en, mem_radrs  memory read strobe / word address
//   mem_data_out         memory read data (valid one cycle after mem_r_en)
//   instr_valid/ready    decode handshake; instr_out / instr_pc payload
//   redirect_valid/pc    branch/jump redirect
//   halt_req, halted     stop fetching / stopped and drained
//   stall_cnt            (only with INSTR_FETCH_STALL_CNT_EN) starved cycles
//
// Optional feature macro: INSTR_FETCH_STALL_CNT_EN
// ----------------------------------------------------------------------------
module instr_fetch #(
   parameter int unsigned        ADDR_W     = 8,
   parameter int unsigned        INSTR_W    = 32,
   parameter int unsigned        FIFO_DEPTH = 4,
   parameter logic [ADDR_W-1:0]  RESET_PC   = '0
) (
   input  logic                clk,
   input  logic                resetn,
   output logic                mem_r_en,
   output logic [ADDR_W-1:0]   mem_radrs,
   input  logic [INSTR_W-1:0]  mem_data_out,
   output logic                instr_valid,
   input  logic                instr_ready,
   output logic [INSTR_W-1:0]  instr_out,
   output logic [ADDR_W-1:0]   instr_pc,
   input  logic                redirect_valid,
   input  logic [ADDR_W-1:0]   redirect_pc,
   input  logic                halt_req,
   output logic                halted
`ifdef INSTR_FETCH_STALL_CNT_EN
  ,output logic [15:0]         stall_cnt
`endif
);

   localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int unsigned CNT_W = PTR_W + 1;

   typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;

   state_t                 state;
   logic [ADDR_W-1:0]      pc;
   logic                   inflight;
   logic [ADDR_W-1:0]      inflight_pc;
   logic [PTR_W-1:0]       rd_ptr;
   logic [PTR_W-1:0]       wr_ptr;
   logic [CNT_W-1:0]       fifo_count;
   logic [ADDR_W-1:0]      fifo_pc   [FIFO_DEPTH];
   logic [INSTR_W-1:0]     fifo_data [FIFO_DEPTH];

   logic                   credit_ok;
   logic                   issue;
   logic                   push;
   logic                   pop;

   // Issue/push/pop decode. The read strobe is decoded in the same cycle as
   // redirect/halt so either one suppresses the request immediately.
   always_comb begin
      credit_ok = (fifo_count + CNT_W'(inflight)) < CNT_W'(FIFO_DEPTH);
      issue     = (state == RUN) && !halt_req && !redirect_valid && credit_ok;
      push      = inflight && !redirect_valid;
      pop       = (fifo_count != '0) && instr_ready && !redirect_valid;
   end

   // Output decode; payload is forced to zero while the buffer is empty.
   always_comb begin
      mem_r_en    = issue;
      mem_radrs   = issue ? pc : '0;
      instr_valid = (fifo_count != '0);
      instr_out   = instr_valid ? fifo_data[rd_ptr] : '0;
      instr_pc    = instr_valid ? fifo_pc[rd_ptr]   : '0;
      halted      = (state == HALT) && (fifo_count == '0);
   end

   // Control state: FSM, pc, inflight tracking and FIFO pointers.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state       <= IDLE;
         pc          <= RESET_PC;
         inflight    <= 1'b0;
         inflight_pc <= '0;
         rd_ptr      <= '0;
         wr_ptr      <= '0;
         fifo_count  <= '0;
      end else if (redirect_valid) begin
         // Flush everything, including a response due this cycle.
         state      <= RUN;
         pc         <= redirect_pc;
         inflight   <= 1'b0;
         rd_ptr     <= '0;
         wr_ptr     <= '0;
         fifo_count <= '0;
      end else begin
         inflight <= issue;
         if (issue) begin
            inflight_pc <= pc;
            pc          <= pc + ADDR_W'(1);
         end
         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         case ({push, pop})
            2'b10:   fifo_count <= fifo_count + CNT_W'(1);
            2'b01:   fifo_count <= fifo_count - CNT_W'(1);
            default: fifo_count <= fifo_count;
         endcase
         case (state)
            IDLE:    state <= RUN;
            // Wait for the outstanding response to land before halting.
            RUN:     if (halt_req && !inflight) state <= HALT;
            HALT:    state <= HALT;
            default: state <= IDLE;
         endcase
      end
   end

   // Buffer storage; contents are only observed through the count.
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_pc[wr_ptr]   <= inflight_pc;
         fifo_data[wr_ptr] <= mem_data_out;
      end
   end

`ifdef INSTR_FETCH_STALL_CNT_EN
   // Cycles where decode is starved and no request could be issued.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         stall_cnt <= '0;
      end else if (redirect_valid) begin
         stall_cnt <= '0;
      end else if ((state == RUN) && (fifo_count == '0) && !issue &&
                   (stall_cnt != 16'hFFFF)) begin
         stall_cnt <= stall_cnt + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// ----------------------------------------------------------------------------
// tb_instr_fetch -- directed self-checking bench for instr_fetch.
// Memory model returns 32'hA000_0000 + address one cycle after a strobe and
// a poison word otherwise. Inputs change at posedge+1, outputs are sampled
// on the falling edge.
// ----------------------------------------------------------------------------
module tb_instr_fetch;

   localparam int unsigned ADDR_W  = 8;
   localparam int unsigned INSTR_W = 32;

   logic                clk            = 1'b0;
   logic                resetn         = 1'b1;
   logic                mem_r_en;
   logic [ADDR_W-1:0]   mem_radrs;
   logic [INSTR_W-1:0]  mem_data_out   = 32'hDEAD_BEEF;
   logic                instr_valid;
   logic                instr_ready    = 1'b0;
   logic [INSTR_W-1:0]  instr_out;
   logic [ADDR_W-1:0]   instr_pc;
   logic                redirect_valid = 1'b0;
   logic [ADDR_W-1:0]   redirect_pc    = '0;
   logic                halt_req       = 1'b0;
   logic                halted;
`ifdef INSTR_FETCH_STALL_CNT_EN
   logic [15:0]         stall_cnt;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   logic [ADDR_W-1:0]  got_pc   [$];
   logic [INSTR_W-1:0] got_data [$];
   logic [ADDR_W-1:0]  issued   [$];

   instr_fetch #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W), .FIFO_DEPTH(4), .RESET_PC(8'h00)) dut (
      .clk            (clk),
      .resetn         (resetn),
      .mem_r_en       (mem_r_en),
      .mem_radrs      (mem_radrs),
      .mem_data_out   (mem_data_out),
      .instr_valid    (instr_valid),
      .instr_ready    (instr_ready),
      .instr_out      (instr_out),
      .instr_pc       (instr_pc),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .halt_req       (halt_req),
      .halted         (halted)
`ifdef INSTR_FETCH_STALL_CNT_EN
     ,.stall_cnt      (stall_cnt)
`endif
   );

   always #5 clk = ~clk;

   // Synchronous instruction memory.
   always @(posedge clk)
      mem_data_out <= mem_r_en ? (32'hA000_0000 + 32'(mem_radrs)) : 32'hDEAD_BEEF;

   // Record deliveries and issued addresses.
   always @(negedge clk) begin
      if (resetn) begin
         if (instr_valid && instr_ready && !redirect_valid) begin
            got_pc.push_back(instr_pc);
            got_data.push_back(instr_out);
         end
         if (mem_r_en) issued.push_back(mem_radrs);
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout want $finish");
      $fatal(1, "timeout");
   end

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   // Leaves the bench in cycle 0 (first cycle after release).
   task automatic apply_reset();
      next_cycle();
      resetn = 1'b0;
      redirect_valid = 1'b0;
      halt_req = 1'b0;
      next_cycle();
      next_cycle();
      resetn = 1'b1;
      got_pc.delete(); got_data.delete(); issued.delete();
   endtask

   task automatic test_reset();
      next_cycle();
      resetn = 1'b0;
      #1;
      n_checks++; if (mem_r_en !== 1'b0)     begin n_fail++; $display("FAIL reset_mem_r_en: got %b want 0", mem_r_en); end
      n_checks++; if (mem_radrs !== 8'h00)   begin n_fail++; $display("FAIL reset_mem_radrs: got %h want 00", mem_radrs); end
      n_checks++; if (instr_valid !== 1'b0)  begin n_fail++; $display("FAIL reset_instr_valid: got %b want 0", instr_valid); end
      n_checks++; if (instr_out !== 32'h0)   begin n_fail++; $display("FAIL reset_instr_out: got %h want 0", instr_out); end
      n_checks++; if (instr_pc !== 8'h00)    begin n_fail++; $display("FAIL reset_instr_pc: got %h want 00", instr_pc); end
      n_checks++; if (halted !== 1'b0)       begin n_fail++; $display("FAIL reset_halted: got %b want 0", halted); end
   endtask

   task automatic test_startup();
      instr_ready = 1'b1;
      apply_reset();
      @(negedge clk);
      n_checks++; if (mem_r_en !== 1'b0) begin n_fail++; $display("FAIL start_c0_mem_r_en: got %b want 0", mem_r_en); end
      next_cycle(); @(negedge clk);
      n_checks++; if (mem_r_en !== 1'b1 || mem_radrs !== 8'h00) begin n_fail++; $display("FAIL start_c1_req: got en=%b adr=%h want en=1 adr=00", mem_r_en, mem_radrs); end
      next_cycle(); @(negedge clk);
      n_checks++; if (instr_valid !== 1'b0 || mem_radrs !== 8'h01) begin n_fail++; $display("FAIL start_c2: got v=%b adr=%h want v=0 adr=01", instr_valid, mem_radrs); end
      next_cycle(); @(negedge clk);
      n_checks++; if (instr_valid !== 1'b1 || instr_pc !== 8'h00 || instr_out !== 32'hA000_0000) begin n_fail++; $display("FAIL start_c3_first: got v=%b pc=%h d=%h want v=1 pc=00 d=a0000000", instr_valid, instr_pc, instr_out); end
      for (int k = 1; k <= 5; k++) begin
         next_cycle(); @(negedge clk);
         n_checks++; if (instr_valid !== 1'b1 || instr_pc !== 8'(k) || instr_out !== 32'hA000_0000 + 32'(k)) begin n_fail++; $display("FAIL start_stream_%0d: got v=%b pc=%h d=%h want v=1 pc=%h", k, instr_valid, instr_pc, instr_out, 8'(k)); end
      end
   endtask

   task automatic test_fill();
      instr_ready = 1'b0;
      apply_reset();
      repeat (10) next_cycle();
      @(negedge clk);
      n_checks++; if (issued.size() != 4) begin n_fail++; $display("FAIL fill_req_count: got %0d want 4", issued.size()); end
      n_checks++; if (mem_r_en !== 1'b0 || instr_valid !== 1'b1 || instr_pc !== 8'h00) begin n_fail++; $display("FAIL fill_full: got en=%b v=%b pc=%h want en=0 v=1 pc=00", mem_r_en, instr_valid, instr_pc); end
      next_cycle();
      instr_ready = 1'b1;
      got_pc.delete(); got_data.delete();
      repeat (8) next_cycle();
      n_checks++; if (got_pc.size() < 4) begin n_fail++; $display("FAIL fill_drain_count: got %0d want >=4", got_pc.size()); end
      for (int i = 0; i < got_pc.size(); i++) begin
         n_checks++; if (got_pc[i] !== 8'(i) || got_data[i] !== 32'hA000_0000 + 32'(i)) begin n_fail++; $display("FAIL fill_order_%0d: got pc=%h d=%h want pc=%h", i, got_pc[i], got_data[i], 8'(i)); end
      end
   endtask

   task automatic test_redirect();
      instr_ready = 1'b0;
      apply_reset();
      repeat (5) next_cycle();
      redirect_valid = 1'b1; redirect_pc = 8'h40; instr_ready = 1'b1;
      @(negedge clk);
      n_checks++; if (mem_r_en !== 1'b0 || instr_valid !== 1'b1) begin n_fail++; $display("FAIL redir_cycle: got en=%b v=%b want en=0 v=1", mem_r_en, instr_valid); end
      next_cycle();
      redirect_valid = 1'b0;
      got_pc.delete(); got_data.delete();
      @(negedge clk);
      n_checks++; if (instr_valid !== 1'b0 || mem_r_en !== 1'b1 || mem_radrs !== 8'h40) begin n_fail++; $display("FAIL redir_next: got v=%b en=%b adr=%h want v=0 en=1 adr=40", instr_valid, mem_r_en, mem_radrs); end
      repeat (8) next_cycle();
      n_checks++; if (got_pc.size() < 4) begin n_fail++; $display("FAIL redir_count: got %0d want >=4", got_pc.size()); end
      for (int i = 0; i < got_pc.size(); i++) begin
         n_checks++; if (got_pc[i] !== 8'h40 + 8'(i) || got_data[i] !== 32'hA000_0040 + 32'(i)) begin n_fail++; $display("FAIL redir_order_%0d: got pc=%h d=%h want pc=%h", i, got_pc[i], got_data[i], 8'h40 + 8'(i)); end
      end
   endtask

   task automatic test_wrap();
      logic [ADDR_W-1:0] exp_pc [4];
      exp_pc = '{8'hFE, 8'hFF, 8'h00, 8'h01};
      instr_ready = 1'b1;
      next_cycle();
      redirect_valid = 1'b1; redirect_pc = 8'hFE;
      next_cycle();
      redirect_valid = 1'b0;
      got_pc.delete(); got_data.delete();
      repeat (8) next_cycle();
      n_checks++; if (got_pc.size() < 4) begin n_fail++; $display("FAIL wrap_count: got %0d want >=4", got_pc.size()); end
      for (int i = 0; i < 4 && i < got_pc.size(); i++) begin
         n_checks++; if (got_pc[i] !== exp_pc[i] || got_data[i] !== 32'hA000_0000 + 32'(exp_pc[i])) begin n_fail++; $display("FAIL wrap_%0d: got pc=%h d=%h want pc=%h", i, got_pc[i], got_data[i], exp_pc[i]); end
      end
   endtask

   task automatic test_halt();
      instr_ready = 1'b0;
      apply_reset();
      repeat (4) next_cycle();
      halt_req = 1'b1; instr_ready = 1'b1;
      got_pc.delete(); got_data.delete(); issued.delete();
      @(negedge clk);
      n_checks++; if (mem_r_en !== 1'b0) begin n_fail++; $display("FAIL halt_no_issue: got %b want 0", mem_r_en); end
      repeat (5) next_cycle();
      @(negedge clk);
      n_checks++; if (halted !== 1'b1 || instr_valid !== 1'b0) begin n_fail++; $display("FAIL halt_done: got halted=%b v=%b want 1 0", halted, instr_valid); end
      n_checks++; if (got_pc.size() != 3) begin n_fail++; $display("FAIL halt_drain_count: got %0d want 3", got_pc.size()); end
      for (int i = 0; i < 3 && i < got_pc.size(); i++) begin
         n_checks++; if (got_pc[i] !== 8'(i) || got_data[i] !== 32'hA000_0000 + 32'(i)) begin n_fail++; $display("FAIL halt_drain_%0d: got pc=%h d=%h want pc=%h", i, got_pc[i], got_data[i], 8'(i)); end
      end
      next_cycle();
      halt_req = 1'b0;
      repeat (3) next_cycle();
      @(negedge clk);
      n_checks++; if (halted !== 1'b1 || mem_r_en !== 1'b0 || issued.size() != 0) begin n_fail++; $display("FAIL halt_sticky: got halted=%b en=%b issued=%0d want 1 0 0", halted, mem_r_en, issued.size()); end
      next_cycle();
      redirect_valid = 1'b1; redirect_pc = 8'h10;
      next_cycle();
      redirect_valid = 1'b0;
      got_pc.delete(); got_data.delete();
      @(negedge clk);
      n_checks++; if (halted !== 1'b0 || mem_r_en !== 1'b1 || mem_radrs !== 8'h10) begin n_fail++; $display("FAIL halt_resume: got halted=%b en=%b adr=%h want 0 1 10", halted, mem_r_en, mem_radrs); end
      repeat (4) next_cycle();
      n_checks++; if (got_pc.size() < 1 || got_pc[0] !== 8'h10 || got_data[0] !== 32'hA000_0010) begin n_fail++; $display("FAIL halt_resume_data: got n=%0d want first pc=10", got_pc.size()); end
   endtask

   task automatic test_reset_mid();
      instr_ready = 1'b1;
      repeat (3) next_cycle();
      resetn = 1'b0;
      #1;
      n_checks++; if (mem_r_en !== 1'b0 || mem_radrs !== 8'h00 || instr_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_req: got en=%b adr=%h v=%b want 0 00 0", mem_r_en, mem_radrs, instr_valid); end
      n_checks++; if (instr_out !== 32'h0 || instr_pc !== 8'h00 || halted !== 1'b0) begin n_fail++; $display("FAIL midrst_out: got d=%h pc=%h h=%b want 0 00 0", instr_out, instr_pc, halted); end
      next_cycle();
      next_cycle();
      resetn = 1'b1;
      @(negedge clk);
      n_checks++; if (mem_r_en !== 1'b0 || instr_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_c0: got en=%b v=%b want 0 0", mem_r_en, instr_valid); end
      next_cycle(); @(negedge clk);
      n_checks++; if (mem_r_en !== 1'b1 || mem_radrs !== 8'h00) begin n_fail++; $display("FAIL midrst_c1: got en=%b adr=%h want 1 00", mem_r_en, mem_radrs); end
      next_cycle(); next_cycle(); @(negedge clk);
      n_checks++; if (instr_valid !== 1'b1 || instr_pc !== 8'h00 || instr_out !== 32'hA000_0000) begin n_fail++; $display("FAIL midrst_c3: got v=%b pc=%h d=%h want 1 00 a0000000", instr_valid, instr_pc, instr_out); end
   endtask

   initial begin
      test_reset();
      test_startup();
      test_fill();
      test_redirect();
      test_wrap();
      test_halt();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
